stream_reorder: RTL and testbench
=================================

STREAM_REORDER -- requirements
Module: stream_reorder

Interface
REQ-001 Parameter DATA_W, default 32, width in bits of each data word; legal range 1..256.
REQ-002 Parameter SLICE_W, default 8, width of the runtime slice-size field; slice sizes span 0..2^SLICE_W-1.
REQ-003 Parameter CNT_W, default 32, width of the beat counter.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  input beat offered.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 in_data  input  DATA_W  input word.
REQ-009 in_dir  input  1  stream direction for this beat: 1 = left-stream (<<), 0 = right-stream (>>).
REQ-010 in_slice  input  SLICE_W  slice size for this beat.
REQ-011 out_valid  output  1  result word available.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_data  output  DATA_W  reordered word.
REQ-014 beat_cnt  output  CNT_W  number of beats delivered on the output since reset.

Function
REQ-015 An input transfer occurs when in_valid and in_ready are both 1; an output transfer occurs when out_valid and out_ready are both 1.
REQ-016 in_dir, in_slice and in_data are sampled together, only on the input transfer cycle; each beat carries its own configuration.
REQ-017 Effective slice S: in_slice = 0 is treated as 1; in_slice >= DATA_W makes every beat an identity.
REQ-018 Left-stream: slice k = in_data[k*S +: S], taken from the LSB upward; the last (MSB-end) slice is shorter when DATA_W mod S != 0.
REQ-019 Left-stream output: the slices are concatenated with slice 0 at the MSB end, slice 1 next, and so on; the short slice lands at the LSB end.
REQ-020 Right-stream output equals in_data unchanged for every S.
REQ-021 S = 1 with left-stream gives a full bit reversal; the reorder SHALL be correct for all S, both power-of-2 and non-power-of-2.
REQ-022 Pipeline has two register stages: stage 1 holds data and configuration, stage 2 holds the result; latency from input transfer to out_valid is exactly 2 cycles when out_ready is held at 1.
REQ-023 Stage 2 loads when it is empty or is being drained this cycle; stage 1 advances under the same rule.
REQ-024 in_ready = !s1_valid || stage-1 advance condition; this is combinational from out_ready, and the block sustains 1 beat per cycle under continuous ready.
REQ-025 While out_valid = 1 and out_ready = 0, out_data SHALL stay stable and no beat is dropped or duplicated.
REQ-026 Beats exit in acceptance order.
REQ-027 Simultaneous input and output transfers in one cycle are both honoured.
REQ-028 beat_cnt increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.

Reset
REQ-029 While rst = 1: s1_valid = 0, out_valid = 0, out_data = 0, beat_cnt = 0, in_ready = 0.
REQ-030 In the first cycle after rst deasserts, in_ready = 1.
REQ-031 rst asserted mid-stream discards all in-flight beats, with no output transfer in the reset cycle.

Verification
REQ-032 DATA_W=32, left, S=1, in_data=32'h04030201 -> out_data=32'h8040C020, out_valid 2 cycles after accept.
REQ-033 DATA_W=23, in_data=23'h030201: left with S=3 -> 23'h1008C0; left with S=4 -> 23'h081018.
REQ-034 DATA_W=4, in_data=4'b0001, left with S=1/2/3/4/5/0 -> 1000/0100/0010/0001/0001/1000; right with any S -> 0001.
REQ-035 Back-to-back 8 beats, out_ready toggling pseudo-randomly -> all 8 results in order, match the model, out_data stable while stalled, beat_cnt = 8.
REQ-036 rst pulsed while both stages are full -> out_valid = 0 next cycle, beat_cnt = 0, and the next accepted beat emerges after 2 cycles.
REQ-037 CNT_W=4, 17 beats -> beat_cnt wraps to 0 after the 16th beat and reads 1 at the end.

Source files
------------

// File: rtl/stream_reorder.sv
// Two-stage streaming word reorderer: per beat, either passes the word through
// (right-stream) or emits its LSB-first slices concatenated MSB-first (left-stream).
module stream_reorder #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 8,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_dir,
  input  logic [SLICE_W-1:0] in_slice,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CNT_W-1:0]   beat_cnt
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  // Handshake: a beat moves on a port only in a cycle where valid && ready are
  // both 1; valid never depends on ready, and in_ready may depend on out_ready.

  logic               s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]  s1_data_q, s1_data_d;
  logic               s1_dir_q, s1_dir_d;
  logic [SLICE_W-1:0] s1_slice_q, s1_slice_d;
  logic               s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0]  s2_data_q, s2_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic              s2_load;
  logic              in_fire;
  logic              out_fire;
  logic [31:0]       slice_ext;
  logic [31:0]       eff_slice;
  logic              identity;
  logic [DATA_W-1:0] reord;

  // Destination bit of source bit i for slice size s: slice k = i / s keeps its
  // internal bit order and is placed k slices down from the MSB end.
  function automatic int dest_idx(input int i, input int s);
    int k;
    int base;
    int w;
    k    = i / s;
    base = k * s;
    w    = (DATA_W - base < s) ? (DATA_W - base) : s;
    return DATA_W - base - w + (i - base);
  endfunction

  assign s2_load   = !s2_valid_q || out_ready;
  assign in_ready  = !rst && (!s1_valid_q || s2_load);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid_q && !rst;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = rst ? '0 : s2_data_q;
  assign beat_cnt  = rst ? '0 : cnt_q;

  assign slice_ext = 32'(s1_slice_q);
  assign eff_slice = (slice_ext == 32'd0) ? 32'd1 : slice_ext;
  assign identity  = !s1_dir_q || (eff_slice >= 32'(DATA_W));

  // One fixed permutation per legal slice size, selected by the stored size.
  always_comb begin
    reord = s1_data_q;
    if (!identity) begin
      for (int cs = 1; cs < DATA_W; cs++) begin
        if (eff_slice == 32'(cs)) begin
          for (int i = 0; i < DATA_W; i++) begin
            reord[IDX_W'(dest_idx(i, cs))] = s1_data_q[IDX_W'(i)];
          end
        end
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_dir_d   = s1_dir_q;
    s1_slice_d = s1_slice_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    cnt_d      = cnt_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
      s1_dir_d   = in_dir;
      s1_slice_d = in_slice;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    // Stage 2 only changes when empty or draining, so a stalled result holds.
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = reord;
      end
    end

    if (out_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_dir_q   <= 1'b0;
      s1_slice_q <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_dir_q   <= s1_dir_d;
      s1_slice_q <= s1_slice_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_stream_reorder.sv
// Bench for stream_reorder: 32-bit instance under random traffic with a
// scoreboard, plus 23-bit and 4-bit instances for directed vectors and wrap.
module tb_stream_reorder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // 32-bit instance
  logic        a_in_valid, a_in_ready, a_in_dir, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data, a_beat_cnt;
  logic [7:0]  a_in_slice;
  // 23-bit instance
  logic        b_in_valid, b_in_ready, b_in_dir, b_out_valid, b_out_ready;
  logic [22:0] b_in_data, b_out_data;
  logic [7:0]  b_in_slice;
  logic [31:0] b_beat_cnt;
  // 4-bit instance with a 4-bit beat counter
  logic        c_in_valid, c_in_ready, c_in_dir, c_out_valid, c_out_ready;
  logic [3:0]  c_in_data, c_out_data, c_beat_cnt;
  logic [2:0]  c_in_slice;

  logic rand_ready;
  logic ready_force;
  logic rnd_bit = 1'b1;
  assign a_out_ready = rand_ready ? rnd_bit : ready_force;
  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  stream_reorder #(.DATA_W(32), .SLICE_W(8), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_dir(a_in_dir), .in_slice(a_in_slice),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .beat_cnt(a_beat_cnt));

  stream_reorder #(.DATA_W(23), .SLICE_W(8), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_dir(b_in_dir), .in_slice(b_in_slice),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .beat_cnt(b_beat_cnt));

  stream_reorder #(.DATA_W(4), .SLICE_W(3), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_dir(c_in_dir), .in_slice(c_in_slice),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .beat_cnt(c_beat_cnt));

  // Reference: cut the word into LSB-first slices, then append them in order
  // so slice 0 ends up at the MSB end.
  function automatic logic [255:0] ref_reorder(input logic [255:0] d, input bit left,
                                               input int s, input int w);
    logic [255:0] r;
    logic [255:0] sl;
    logic [255:0] msk;
    int eff;
    int sw;
    eff = (s == 0) ? 1 : s;
    msk = (256'd1 << w) - 256'd1;
    if (!left || eff >= w) return d & msk;
    r = '0;
    for (int pos = 0; pos < w; pos += eff) begin
      sw = (w - pos < eff) ? (w - pos) : eff;
      sl = (d >> pos) & ((256'd1 << sw) - 256'd1);
      r  = (r << sw) | sl;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard for the 32-bit instance
  logic [31:0] exp_q[$];
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [255:0] mdl;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("a_stall_valid", a_out_valid, 1);
        check("a_stall_data", a_out_data, prev_data);
      end
      if (a_out_valid && a_out_ready) begin
        check("a_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("a_out_data", a_out_data, exp_q.pop_front());
      end
      if (a_in_valid && a_in_ready) begin
        mdl = ref_reorder(256'(a_in_data), a_in_dir, int'(a_in_slice), 32);
        exp_q.push_back(mdl[31:0]);
      end
      prev_stall = a_out_valid && !a_out_ready;
      prev_data  = a_out_data;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic send_a(input logic [31:0] d, input logic dir, input logic [7:0] s);
    int t;
    t = 0;
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_dir   = dir;
    a_in_slice = s;
    @(negedge clk);
    while (!a_in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("a_send_accept", t < 100, 1);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_a_rand();
    send_a($urandom, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 40)));
  endtask

  task automatic drain_a(input string tag, input logic [31:0] exp_cnt);
    rand_ready  = 1'b0;
    ready_force = 1'b1;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    @(negedge clk);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_beat_cnt"}, a_beat_cnt, exp_cnt);
    @(posedge clk);
    #1;
  endtask

  task automatic run_b(input string tag, input logic [22:0] d, input logic dir,
                       input logic [7:0] s, input logic [22:0] exp);
    b_in_valid = 1'b1;
    b_in_data  = d;
    b_in_dir   = dir;
    b_in_slice = s;
    @(negedge clk);
    check({tag, "_in_ready"}, b_in_ready, 1);
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_valid"}, b_out_valid, 1);
    check({tag, "_data"}, b_out_data, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic run_c(input string tag, input logic [3:0] d, input logic dir,
                       input logic [2:0] s, input logic [3:0] exp);
    c_in_valid = 1'b1;
    c_in_data  = d;
    c_in_dir   = dir;
    c_in_slice = s;
    @(posedge clk);
    #1;
    c_in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_early"}, c_out_valid, 0);
    @(negedge clk);
    check({tag, "_valid"}, c_out_valid, 1);
    check({tag, "_data"}, c_out_data, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [255:0] m;
    logic [3:0]   vc_d;
    logic         vc_dir;
    logic [2:0]   vc_s;
    logic [22:0]  vb_d;
    logic         vb_dir;
    logic [7:0]   vb_s;
    logic [3:0]   c_exp_left[6];
    logic [2:0]   c_sl[6];

    rst = 1'b1;
    rand_ready = 1'b0;
    ready_force = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_dir = 1'b0; a_in_slice = '0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_dir = 1'b0; b_in_slice = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = '0; c_in_dir = 1'b0; c_in_slice = '0; c_out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_a_in_ready", a_in_ready, 0);
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_out_data", a_out_data, 0);
    check("rst_a_beat_cnt", a_beat_cnt, 0);
    check("rst_c_in_ready", c_in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_a_in_ready", a_in_ready, 1);
    check("post_rst_b_in_ready", b_in_ready, 1);

    // Bit reversal with 2-cycle latency
    @(posedge clk);
    #1;
    send_a(32'h04030201, 1'b1, 8'd1);
    @(negedge clk);
    check("a_lat_cycle1", a_out_valid, 0);
    @(negedge clk);
    check("a_lat_cycle2", a_out_valid, 1);
    check("a_bitrev", a_out_data, 32'h8040C020);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("a_cnt_one", a_beat_cnt, 1);

    // Fill both stages, then reset mid-stream
    @(posedge clk);
    #1;
    ready_force = 1'b0;
    send_a_rand();
    send_a_rand();
    @(negedge clk);
    check("a_full_in_ready", a_in_ready, 0);
    check("a_full_out_valid", a_out_valid, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    ready_force = 1'b1;
    @(negedge clk);
    check("a_rst_out_valid", a_out_valid, 0);
    check("a_rst_beat_cnt", a_beat_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("a_after_rst_valid", a_out_valid, 0);
    check("a_after_rst_cnt", a_beat_cnt, 0);
    check("a_after_rst_ready", a_in_ready, 1);
    @(posedge clk);
    #1;
    send_a_rand();
    @(negedge clk);
    check("a_rst_lat_cycle1", a_out_valid, 0);
    @(negedge clk);
    check("a_rst_lat_cycle2", a_out_valid, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("a_rst_then_cnt", a_beat_cnt, 1);
    @(posedge clk);
    #1;

    // Eight back-to-back beats under toggling out_ready
    pulse_rst();
    rand_ready = 1'b1;
    repeat (8) send_a_rand();
    drain_a("a_b2b8", 32'd8);

    // Long random run with idle gaps
    pulse_rst();
    rand_ready = 1'b1;
    repeat (150) begin
      send_a_rand();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    drain_a("a_rand150", 32'd150);

    // 23-bit directed and random vectors
    run_b("b_left_s3", 23'h030201, 1'b1, 8'd3, 23'h1008C0);
    run_b("b_left_s4", 23'h030201, 1'b1, 8'd4, 23'h081018);
    run_b("b_right_s3", 23'h030201, 1'b0, 8'd3, 23'h030201);
    repeat (20) begin
      vb_d   = 23'($urandom);
      vb_dir = 1'($urandom_range(0, 1));
      vb_s   = 8'($urandom_range(0, 30));
      m = ref_reorder(256'(vb_d), vb_dir, int'(vb_s), 23);
      run_b("b_rand", vb_d, vb_dir, vb_s, m[22:0]);
    end

    // 4-bit table: left with S=1/2/3/4/5/0, right with every S
    c_sl       = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    c_exp_left = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001, 4'b1000};
    for (int i = 0; i < 6; i++) run_c("c_left", 4'b0001, 1'b1, c_sl[i], c_exp_left[i]);
    for (int s = 0; s < 8; s++) run_c("c_right", 4'b0001, 1'b0, 3'(s), 4'b0001);

    // 4-bit beat counter wrap over 17 beats
    pulse_rst();
    for (int i = 1; i <= 17; i++) begin
      vc_d   = 4'($urandom);
      vc_dir = 1'($urandom_range(0, 1));
      vc_s   = 3'($urandom_range(0, 7));
      m = ref_reorder(256'(vc_d), vc_dir, int'(vc_s), 4);
      run_c("c_wrap_beat", vc_d, vc_dir, vc_s, m[3:0]);
      if (i == 15) check("c_cnt_15", c_beat_cnt, 15);
      if (i == 16) check("c_cnt_wrap", c_beat_cnt, 0);
    end
    check("c_cnt_end", c_beat_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
